inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_inst_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Packs the fields of an RV32I instruction into a 32-bit word. The result is
// queued in a 2-entry output FIFO. Requests whose immediate cannot be
// represented in the selected format, and requests with an illegal format
// code, are turned into a NOP and flagged as error entries.
//
// Ports
//   clk        : single clock; all state updates on its rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : request fields below are valid
//   in_ready   : a request can be accepted (FIFO not full)
//   fmt        : 0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal
//   opcode     : copied into inst[6:0]
//   funct3     : copied into inst[14:12] where the format has it
//   funct7     : copied into inst[31:25] for R format
//   rd/rs1/rs2 : register addresses
//   imm        : full two's-complement immediate, not pre-shifted
//   out_valid  : FIFO non-empty; inst/err describe the head entry
//   out_ready  : the consumer takes the head entry
//   inst       : encoded word at the FIFO head
//   err        : head entry was unencodable (inst is then a NOP)
//   enc_count  : accepted requests, wraps at 16 bits
//   err_count  : accepted error requests, saturates at 8'hFF
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid does not depend on ready, and in_ready depends only on the
// registered FIFO occupancy, so there is no combinational path from
// out_ready to in_ready.
// -----------------------------------------------------------------------------
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  // An immediate fits an N-bit signed field when every bit from the field's
  // sign bit upward is a copy of that sign bit.
  logic fits_i;   // imm[31:11] all equal: 12-bit signed
  logic fits_b;   // imm[31:12] all equal: 13-bit signed
  logic fits_j;   // imm[31:20] all equal: 21-bit signed

  assign fits_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_j = (&imm[31:20]) | ~(|imm[31:20]);

  logic [31:0] word;
  logic        enc_err;
  logic [31:0] enc_inst;

  always_comb begin
    word    = NOP;
    enc_err = 1'b0;
    case (fmt)
      FMT_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        word    = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err = ~fits_i;
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err = ~fits_i;
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err = ~fits_b | imm[0];
      end
      FMT_U: begin
        word    = {imm[31:12], rd, opcode};
        enc_err = |imm[11:0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err = ~fits_j | imm[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
    enc_inst = enc_err ? NOP : word;
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO
  // ---------------------------------------------------------------------------
  logic [31:0] mem_inst [2];
  logic        mem_err  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        push;
  logic        pop;
  logic        wr_ptr_n;
  logic        rd_ptr_n;
  logic [1:0]  count_n;
  logic [31:0] head_inst_n;
  logic        head_err_n;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_n = push ? ~wr_ptr : wr_ptr;
    rd_ptr_n = pop  ? ~rd_ptr : rd_ptr;
    count_n  = count + {1'b0, push} - {1'b0, pop};
    // The head after this edge is the entry being written if the write slot
    // is the slot the read pointer will point at (empty FIFO, or push and
    // pop together at occupancy 1); otherwise it is already in storage.
    if (push && (wr_ptr == rd_ptr_n)) begin
      head_inst_n = enc_inst;
      head_err_n  = enc_err;
    end else begin
      head_inst_n = mem_inst[rd_ptr_n];
      head_err_n  = mem_err[rd_ptr_n];
    end
  end

  // Storage is not reset: the pointers and count make stale contents
  // unreachable.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_inst[wr_ptr] <= enc_inst;
      mem_err[wr_ptr]  <= enc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
    end
  end

  // Registered head view; holds its last value while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst <= NOP;
      err  <= 1'b0;
    end else if (count_n != 2'd0) begin
      inst <= head_inst_n;
      err  <= head_err_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= 16'd0;
      err_count <= 8'd0;
    end else if (push) begin
      enc_count <= enc_count + 16'd1;
      if (enc_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//
// Directed bench for inst_encoder. A reference model (format rules written as
// signed range checks plus a queue of expected FIFO entries) is compared to the
// DUT on every falling edge; literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst;
  logic        err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .err       (err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int sent   = 0;   // requests accepted since the last reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Returns {err, inst} for one request.
  function automatic logic [32:0] model_encode(input logic [2:0] f, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    bit          bad;
    s   = $signed(im);
    w   = NOP;
    bad = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin
        bad = (s < -2048) || (s > 2047);
        w   = {im[11:0], s1, f3, d, op};
      end
      3'd2: begin
        bad = (s < -2048) || (s > 2047);
        w   = {im[11:5], s2, s1, f3, im[4:0], op};
      end
      3'd3: begin
        bad = (s < -4096) || (s > 4095) || ((s & 1) != 0);
        w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      end
      3'd4: begin
        bad = (im % 32'd4096) != 0;
        w   = {im[31:12], d, op};
      end
      3'd5: begin
        bad = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((s & 1) != 0);
        w   = {im[20], im[10:1], im[11], im[19:12], d, op};
      end
      default: bad = 1'b1;
    endcase
    if (bad) return {1'b1, NOP};
    return {1'b0, w};
  endfunction

  logic [32:0] exp_q[$];
  logic [31:0] m_inst  = NOP;
  logic        m_err   = 1'b0;
  int          m_enc   = 0;
  int          m_errc  = 0;
  bit          m_live  = 1'b0;

  // Inputs change only just after rising edges, so on the falling edge they
  // describe what the next rising edge will do.
  always @(negedge clk) begin
    bit          acc;
    bit          pop;
    logic [32:0] e;
    if (m_live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_q.size() != 2});
      chk("inst",      inst,               m_inst);
      chk("err",       {31'd0, err},       {31'd0, m_err});
      chk("enc_count", {16'd0, enc_count}, m_enc[31:0] & 32'hFFFF);
      chk("err_count", {24'd0, err_count}, m_errc[31:0]);
    end
    if (rst) begin
      exp_q.delete();
      m_inst = NOP;
      m_err  = 1'b0;
      m_enc  = 0;
      m_errc = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      acc = in_valid && (exp_q.size() != 2);
      pop = (exp_q.size() != 0) && out_ready;
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        e = model_encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
        exp_q.push_back(e);
        m_enc = (m_enc + 1) % 65536;
        if (e[32] && m_errc < 255) m_errc++;
      end
      if (exp_q.size() != 0) {m_err, m_inst} = exp_q[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Presents one request and returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    bit acc;
    int budget;
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    acc    = 1'b0;
    budget = 0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (acc) sent++;
    else chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base_sent;

    // Reset
    rst = 1'b1;
    tick(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_inst",      inst,               NOP);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    sent = 0;
    tick(1);

    // Directed encodings, consumer always ready
    out_ready = 1'b1;
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_inst",  inst, 32'h0050_0093);
    chk("addi_err",   {31'd0, err}, 32'd0);

    send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    chk("jal_inst", inst, 32'h0080_00EF);

    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    chk("beq_inst", inst, 32'hFE20_8EE3);

    send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    chk("lui_inst", inst, 32'h1234_52B7);

    send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    chk("sw_inst", inst, 32'h0020_A423);

    send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF);
    chk("add_inst", inst, 32'h0020_81B3);
    chk("add_err",  {31'd0, err}, 32'd0);

    // Error cases
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    chk("i2048_inst", inst, NOP);
    chk("i2048_err",  {31'd0, err}, 32'd1);
    chk("i2048_errc", {24'd0, err_count}, 32'd1);

    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd6);
    chk("b6_err", {31'd0, err}, 32'd0);

    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5);
    chk("b5_err",  {31'd0, err}, 32'd1);
    chk("b5_errc", {24'd0, err_count}, 32'd2);

    // Boundary immediates (checked by the model)
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048);
    send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2047);
    send(3'd3, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4096);
    send(3'd3, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, -32'sd4096);
    send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
    send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000);
    send(3'd4, 7'b0010111, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h0000_0800);
    send(3'd6, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    chk("fmt6_err", {31'd0, err}, 32'd1);
    tick(2);
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: the third request must wait for room
    out_ready = 1'b0;
    base_sent = sent;
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'd1);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd11, 5'd0, 5'd0, 32'd2);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd12, 5'd0, 5'd0, 32'd3);
      begin
        tick(3);
        chk("held_enc_count", {16'd0, enc_count}, base_sent + 2);
        chk("held_head", inst, 32'h0010_0513);
        out_ready = 1'b1;
      end
    join
    chk("bp_enc_count", {16'd0, enc_count}, base_sent + 3);
    tick(3);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Continuous stream with the consumer always ready
    base_sent = sent;
    for (int i = 0; i < 24; i++) begin
      send(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
           7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 32'($signed($urandom_range(0, 8191)) - 4096));
    end
    chk("stream_count", {16'd0, enc_count}, base_sent + 24);
    tick(2);

    // err_count saturation
    for (int i = 0; i < 260; i++) begin
      send(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    end
    chk("err_sat", {24'd0, err_count}, 32'hFF);
    chk("enc_after_sat", {16'd0, enc_count}, sent);
    tick(2);

    // Reset with two entries queued, colliding with an accept and a pop
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd8);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick(1);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_enc_count", {16'd0, enc_count}, 32'd0);
    chk("rst2_err_count", {24'd0, err_count}, 32'd0);
    chk("rst2_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst2_inst",      inst,               NOP);
    rst = 1'b0;
    in_valid = 1'b0;
    sent = 0;
    tick(1);

    // FIFO restarts cleanly
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("post_rst_inst",  inst, 32'h0050_0093);
    chk("post_rst_count", {16'd0, enc_count}, 32'd1);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
